conv_feeder: RTL and testbench
==============================

# conv_feeder

Upstream feeder for the PE. Captures one kernel of `KernelSize` FP32 weights, then streams activations and reuses the stored weights every block. It presents lock-stepped W/I/O beats to the PE's three valid/ready input channels, with a partial-sum seed on tap 0 of each block and +0.0 on the other taps. The block does no arithmetic; it is a control, buffering and handshake stage.

## Interface
Parameters:
- `DataWidth`, 32: FP32 word width.
- `KernelSize`, 4: taps per block; must be ≥2.
- `TapWidth`, 2: tap counter width, equal to ceil(log2(KernelSize)).
- `BlkWidth`, 16: width of the block count.

Ports:
- `clk`  in  1  clock. One clock domain; every register is rising-edge.
- `aclr_n`  in  1  reset. Asynchronous assert, active-low.
- `cfg_start`  in  1  start pulse; sampled only in IDLE.
- `cfg_num_blocks`  in  BlkWidth  number of blocks; latched on start.
- `WL_DataIn` / `WL_DataInValid` / `WL_DataInRdy`  in/in/out  DataWidth/1/1  weight load stream.
- `A_DataIn` / `A_DataInValid` / `A_DataInRdy`  in/in/out  DataWidth/1/1  activation stream.
- `P_DataIn` / `P_DataInValid` / `P_DataInRdy`  in/in/out  DataWidth/1/1  partial-sum seed stream, one word per block.
- `W_DataOut` / `W_DataOutValid`  out  DataWidth/1  weight to PE; `W_DataOutRdy` in, 1.
- `I_DataOut` / `I_DataOutValid`  out  DataWidth/1  activation to PE; `I_DataOutRdy` in, 1.
- `O_DataOut` / `O_DataOutValid`  out  DataWidth/1  psum to PE; `O_DataOutRdy` in, 1.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the final beat transfers.

## Operation
- States are IDLE → LOAD → STREAM → DONE → IDLE.
- IDLE:
  - `cfg_start`=1 latches `cfg_num_blocks`.
  - If the latched count is 0, go to DONE; no weights are loaded.
  - Otherwise go to LOAD.
- LOAD:
  - `WL_DataInRdy`=1.
  - Each WL handshake writes `wbuf[wptr]` and increments `wptr`.
  - After the `KernelSize`-th word, go to STREAM with `tap`=0 and `blk`=0.
- STREAM beat, emitted for each tap:
  - W carries `wbuf[tap]`.
  - I carries `A_DataIn`.
  - O carries `P_DataIn` when `tap`==0, otherwise 32'h0000_0000.
- Beat acceptance requires all of:
  - `A_DataInValid`.
  - `P_DataInValid`, only when `tap`==0.
  - Output slot free: `!out_valid` or `fire`.
- `A_DataInRdy` and `P_DataInRdy` are asserted only when the other conditions for acceptance hold; `P_DataInRdy` is additionally gated by `tap`==0. No input word is ever consumed without its partners.
- `fire` = `out_valid` & `W_DataOutRdy` & `I_DataOutRdy` & `O_DataOutRdy`. The three Valid outputs are the same `out_valid`, and the three channels always transfer together.
- Counters advance on acceptance:
  - `tap` wraps at `KernelSize`-1.
  - On wrap, `blk` increments.
  - Accepting the last tap of block `num_blocks`-1 stops further acceptance.
- Leave STREAM once that last beat has fired. Go to DONE, which lasts one cycle with `done`=1, then return to IDLE.
- `wbuf` holds its contents across runs, but each run always reloads it in LOAD.

## Timing
- Reset: state IDLE, all `*_DataOut`=0, all Valid=0, all input Rdy=0, `busy`=0, `done`=0, counters 0.
- Reset asserted mid-run aborts the run immediately: any in-flight beat is dropped, and the next run needs a fresh `cfg_start`.
- Latency: an input accepted at edge n appears with Valid=1 after edge n; `fire` can occur at the earliest on edge n+1.
- Throughput: one beat per cycle while the inputs are valid and the PE is ready.
- Backpressure: while `out_valid`=1 and `fire`=0, all outputs stay stable and no input is accepted.
- No combinational path from an input Valid to an output Valid. Input Rdy depends combinationally on the output Rdy signals, through `fire`.
- `cfg_start` in any state other than IDLE is ignored, and `cfg_num_blocks` changes after the latch have no effect.
- WL words offered outside LOAD are not accepted.
- Unknown/X on inputs whose Rdy=0 must not propagate.

## Structure
- Package `conv_pkg`:
  - `DataWidth`.
  - `FP32_ZERO` = 32'h0000_0000.
  - State enum `feeder_state_t` {IDLE, LOAD, STREAM, DONE}.
- Sub-module `feeder_weight_buf`:
  - `KernelSize`×`DataWidth` register file.
  - One synchronous write port and one combinational read port.
  - Async active-low clear.
- The FSM, counters and output register stay in `conv_feeder`.

## Test plan
- Reset values:
  - Stimulus: hold `aclr_n`=0 while driving random inputs.
  - Response: all outputs 0, all Rdy 0, and nothing changes when the clock runs.
- Nominal run:
  - Stimulus: `num_blocks`=2; load weights 40a00000, 41200000, 41700000, 41a00000 (5, 10, 15, 20); activations 1..8; seeds 41200000 (10) and 0; all PE Rdy=1.
  - Response: 8 beats. W cycles 5, 10, 15, 20 twice. I is 1..8. O is 10, 0, 0, 0, 0, 0, 0, 0. `done` pulses exactly once, one cycle after the last fire.
- Backpressure:
  - Stimulus: drop `O_DataOutRdy` alone for 3 cycles mid-block.
  - Response: outputs hold for those cycles, `A_DataInRdy`=0, and no beat is lost or duplicated.
- Seed starvation:
  - Stimulus: `P_DataInValid`=0 at `tap`=0 while `A_DataInValid`=1.
  - Response: no beat and `A_DataInRdy`=0. The beat is emitted one cycle after `P_DataInValid` rises.
- Zero blocks:
  - Stimulus: `cfg_num_blocks`=0.
  - Response: `WL_DataInRdy` never rises; `done` pulses 2 cycles after `cfg_start`.
- Mid-stream reset:
  - Stimulus: assert `aclr_n`=0 after 5 fires.
  - Response: outputs clear immediately. A new `cfg_start` replays LOAD from `wptr`=0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution feeder slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_pkg;

  localparam int DataWidth = 32;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/feeder_weight_buf.sv
// Kernel weight register file: one synchronous write port, one combinational read port.
// Latency: a write is visible on the read port the cycle after its write edge.
// Backpressure: none; the writer qualifies every write with wrEn.
//
// Ports:
//   clk, aclr_n      clock and asynchronous active-low clear (clears every entry)
//   wrEn/wrAddr/wrData  write port
//   rdAddr/rdData    combinational read port
module feeder_weight_buf #(
  parameter int DataWidth  = 32,
  parameter int KernelSize = 4,
  parameter int TapWidth   = 2
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 wrEn,
  input  logic [TapWidth-1:0]  wrAddr,
  input  logic [DataWidth-1:0] wrData,
  input  logic [TapWidth-1:0]  rdAddr,
  output logic [DataWidth-1:0] rdData
);
  import conv_pkg::*;

  logic [DataWidth-1:0] mem [KernelSize];

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int k = 0; k < KernelSize; k++) begin
        mem[k] <= '0;
      end
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/conv_feeder.sv
// PE feeder: loads one kernel of weights, then streams lock-stepped W/I/O beats per tap.
// Latency: an input accepted at edge n is presented valid after edge n.
// Backpressure: a held output beat blocks all input acceptance; input Rdy follows PE Rdy via fire.
//
// Ports:
//   clk, aclr_n                    clock, asynchronous active-low reset
//   cfg_start, cfg_num_blocks      run start pulse (IDLE only) and block count
//   WL_DataIn*/WL_DataInRdy        weight load stream (accepted only in LOAD)
//   A_DataIn*/A_DataInRdy          activation stream, one word per tap
//   P_DataIn*/P_DataInRdy          partial-sum seed stream, one word per block (tap 0)
//   W_/I_/O_DataOut*               weight, activation and psum beats to the PE
//   busy, done                     run status, one-cycle completion pulse
module conv_feeder #(
  parameter int DataWidth  = 32,
  parameter int KernelSize = 4,
  parameter int TapWidth   = 2,
  parameter int BlkWidth   = 16
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 cfg_start,
  input  logic [BlkWidth-1:0]  cfg_num_blocks,
  input  logic [DataWidth-1:0] WL_DataIn,
  input  logic                 WL_DataInValid,
  output logic                 WL_DataInRdy,
  input  logic [DataWidth-1:0] A_DataIn,
  input  logic                 A_DataInValid,
  output logic                 A_DataInRdy,
  input  logic [DataWidth-1:0] P_DataIn,
  input  logic                 P_DataInValid,
  output logic                 P_DataInRdy,
  output logic [DataWidth-1:0] W_DataOut,
  output logic                 W_DataOutValid,
  input  logic                 W_DataOutRdy,
  output logic [DataWidth-1:0] I_DataOut,
  output logic                 I_DataOutValid,
  input  logic                 I_DataOutRdy,
  output logic [DataWidth-1:0] O_DataOut,
  output logic                 O_DataOutValid,
  input  logic                 O_DataOutRdy,
  output logic                 busy,
  output logic                 done
);
  import conv_pkg::*;

  localparam logic [TapWidth-1:0] LastTap = TapWidth'(KernelSize - 1);

  feeder_state_t        state;
  logic [BlkWidth-1:0]  numBlocks;
  logic [BlkWidth-1:0]  blk;
  logic [TapWidth-1:0]  wptr;
  logic [TapWidth-1:0]  tap;
  logic                 lastTaken;   // final beat of the run has been accepted
  logic                 outValid;
  logic [DataWidth-1:0] wOut;
  logic [DataWidth-1:0] iOut;
  logic [DataWidth-1:0] oOut;
  logic [DataWidth-1:0] wRd;

  logic fire;
  logic slotFree;
  logic streaming;
  logic tapZero;
  logic accept;
  logic wlTake;
  logic lastTapHit;
  logic lastBlkHit;

  // The three PE channels share one valid and transfer only together.
  assign fire       = outValid & W_DataOutRdy & I_DataOutRdy & O_DataOutRdy;
  assign slotFree   = ~outValid | fire;
  assign streaming  = (state == STREAM) & ~lastTaken;
  assign tapZero    = (tap == '0);
  assign lastTapHit = (tap == LastTap);
  assign lastBlkHit = (blk == numBlocks - 1'b1);

  // Each Rdy is qualified by its partner's Valid so no word is taken alone.
  assign A_DataInRdy = streaming & slotFree & (~tapZero | P_DataInValid);
  assign P_DataInRdy = streaming & slotFree & tapZero & A_DataInValid;
  assign accept      = A_DataInRdy & A_DataInValid;

  // A zero block count never opens the weight port.
  assign WL_DataInRdy = (state == LOAD) & (numBlocks != '0);
  assign wlTake       = WL_DataInRdy & WL_DataInValid;

  feeder_weight_buf #(
    .DataWidth (DataWidth),
    .KernelSize(KernelSize),
    .TapWidth  (TapWidth)
  ) u_wbuf (
    .clk   (clk),
    .aclr_n(aclr_n),
    .wrEn  (wlTake),
    .wrAddr(wptr),
    .wrData(WL_DataIn),
    .rdAddr(tap),
    .rdData(wRd)
  );

  // Control: the zero-count decision is taken on the latched count in the
  // cycle after start, so a zero-block run passes LOAD with the port closed.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state     <= IDLE;
      numBlocks <= '0;
      blk       <= '0;
      wptr      <= '0;
      tap       <= '0;
      lastTaken <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            numBlocks <= cfg_num_blocks;
            blk       <= '0;
            wptr      <= '0;
            tap       <= '0;
            lastTaken <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (numBlocks == '0) begin
            state <= DONE;
          end else if (wlTake) begin
            if (wptr == LastTap) begin
              wptr  <= '0;
              tap   <= '0;
              blk   <= '0;
              state <= STREAM;
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            if (lastTapHit) begin
              tap <= '0;
              blk <= blk + 1'b1;
              if (lastBlkHit) begin
                lastTaken <= 1'b1;
              end
            end else begin
              tap <= tap + 1'b1;
            end
          end
          if (lastTaken & fire) begin
            state <= DONE;
          end
        end
        DONE: begin
          lastTaken <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output beat register: reloads on acceptance, empties on a fire with no refill.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      outValid <= 1'b0;
      wOut     <= '0;
      iOut     <= '0;
      oOut     <= '0;
    end else if (accept) begin
      outValid <= 1'b1;
      wOut     <= wRd;
      iOut     <= A_DataIn;
      oOut     <= tapZero ? P_DataIn : DataWidth'(FP32_ZERO);
    end else if (fire) begin
      outValid <= 1'b0;
    end
  end

  assign W_DataOut      = wOut;
  assign I_DataOut      = iOut;
  assign O_DataOut      = oOut;
  assign W_DataOutValid = outValid;
  assign I_DataOutValid = outValid;
  assign O_DataOutValid = outValid;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_conv_feeder.sv
module tb_conv_feeder;

  logic        clk = 1'b0;
  logic        aclr_n;
  logic        cfg_start;
  logic [15:0] cfg_num_blocks;
  logic [31:0] WL_DataIn;
  logic        WL_DataInValid;
  logic        WL_DataInRdy;
  logic [31:0] A_DataIn;
  logic        A_DataInValid;
  logic        A_DataInRdy;
  logic [31:0] P_DataIn;
  logic        P_DataInValid;
  logic        P_DataInRdy;
  logic [31:0] W_DataOut;
  logic        W_DataOutValid;
  logic        W_DataOutRdy;
  logic [31:0] I_DataOut;
  logic        I_DataOutValid;
  logic        I_DataOutRdy;
  logic [31:0] O_DataOut;
  logic        O_DataOutValid;
  logic        O_DataOutRdy;
  logic        busy;
  logic        done;

  conv_feeder #(
    .DataWidth (32),
    .KernelSize(4),
    .TapWidth  (2),
    .BlkWidth  (16)
  ) dut (
    .clk           (clk),
    .aclr_n        (aclr_n),
    .cfg_start     (cfg_start),
    .cfg_num_blocks(cfg_num_blocks),
    .WL_DataIn     (WL_DataIn),
    .WL_DataInValid(WL_DataInValid),
    .WL_DataInRdy  (WL_DataInRdy),
    .A_DataIn      (A_DataIn),
    .A_DataInValid (A_DataInValid),
    .A_DataInRdy   (A_DataInRdy),
    .P_DataIn      (P_DataIn),
    .P_DataInValid (P_DataInValid),
    .P_DataInRdy   (P_DataInRdy),
    .W_DataOut     (W_DataOut),
    .W_DataOutValid(W_DataOutValid),
    .W_DataOutRdy  (W_DataOutRdy),
    .I_DataOut     (I_DataOut),
    .I_DataOutValid(I_DataOutValid),
    .I_DataOutRdy  (I_DataOutRdy),
    .O_DataOut     (O_DataOut),
    .O_DataOutValid(O_DataOutValid),
    .O_DataOutRdy  (O_DataOutRdy),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int fireCount   = 0;
  int lastFireCyc = -1;
  int doneCount   = 0;
  int doneCyc     = -1;
  int startCyc    = 0;

  logic [95:0] expQ[$];
  logic [31:0] wts[4];
  logic [31:0] acts[8];
  logic [31:0] seeds[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Scoreboard monitor: every PE transfer pops and compares one expected beat.
  logic [95:0] expBeat;
  always @(negedge clk) begin
    if (aclr_n === 1'b1) begin
      if (done === 1'b1) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (W_DataOutValid && W_DataOutRdy && I_DataOutRdy && O_DataOutRdy) begin
        fireCount++;
        lastFireCyc = cyc;
        if (expQ.size() == 0) begin
          chk("extra_beat", 128'(expQ.size()), 128'(1));
        end else begin
          expBeat = expQ.pop_front();
          chk("beat", 128'({I_DataOutValid, O_DataOutValid, W_DataOut, I_DataOut, O_DataOut}),
              128'({2'b11, expBeat}));
        end
      end
    end
  end

  // Expected beats for the current weights/acts/seeds tables.
  task automatic expectBeats(input int n);
    for (int k = 0; k < n; k++) begin
      expQ.push_back({wts[k % 4], acts[k], (k % 4 == 0) ? seeds[k / 4] : 32'h0000_0000});
    end
  endtask

  task automatic startRun(input logic [15:0] n);
    @(posedge clk); #1;
    cfg_num_blocks = n;
    cfg_start      = 1'b1;
    startCyc       = cyc;
    @(posedge clk); #1;
    cfg_start      = 1'b0;
    cfg_num_blocks = 16'hBEEF;
  endtask

  task automatic loadW();
    for (int k = 0; k < 4; k++) begin
      bit hs;
      int g;
      hs = 1'b0;
      g  = 0;
      WL_DataIn      = wts[k];
      WL_DataInValid = 1'b1;
      while (!hs && g < 50) begin
        @(negedge clk);
        hs = WL_DataInRdy;
        @(posedge clk); #1;
        g++;
      end
      chk("wl_handshake", 128'(hs), 128'(1));
    end
    WL_DataInValid = 1'b0;
  endtask

  task automatic pushA(input logic [31:0] a, input bit hasSeed, input logic [31:0] s,
                       input int seedDelay);
    bit hs;
    int g;
    hs = 1'b0;
    g  = 0;
    A_DataIn      = a;
    A_DataInValid = 1'b1;
    P_DataIn      = s;
    while (!hs && g < 100) begin
      P_DataInValid = hasSeed && (g >= seedDelay);
      @(negedge clk);
      if (g < seedDelay) chk("starve_ardy", 128'({A_DataInRdy, W_DataOutValid}), 128'(0));
      hs = A_DataInRdy;
      @(posedge clk); #1;
      g++;
    end
    A_DataInValid = 1'b0;
    P_DataInValid = 1'b0;
    chk("a_handshake", 128'(hs), 128'(1));
  endtask

  task automatic waitIdle(output bit wlSeen);
    int g;
    g      = 0;
    wlSeen = 1'b0;
    do begin
      @(negedge clk);
      wlSeen = wlSeen | WL_DataInRdy;
      g++;
    end while (busy && g < 100);
    chk("idle_reached", 128'(busy), 128'(0));
  endtask

  task automatic waitFires(input int target);
    int g;
    g = 0;
    while (fireCount < target && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("fire_count", 128'(fireCount >= target), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wlSeen;
    int base;

    aclr_n = 1'b0; cfg_start = 1'b0; cfg_num_blocks = '0;
    WL_DataIn = '0; WL_DataInValid = 1'b0;
    A_DataIn = '0; A_DataInValid = 1'b0;
    P_DataIn = '0; P_DataInValid = 1'b0;
    W_DataOutRdy = 1'b0; I_DataOutRdy = 1'b0; O_DataOutRdy = 1'b0;

    // Reset held with random inputs: everything stays zero.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      cfg_start      = 1'($urandom);
      cfg_num_blocks = 16'($urandom);
      WL_DataIn      = $urandom;
      WL_DataInValid = 1'($urandom);
      A_DataIn       = $urandom;
      A_DataInValid  = 1'($urandom);
      P_DataIn       = $urandom;
      P_DataInValid  = 1'($urandom);
      W_DataOutRdy   = 1'($urandom);
      I_DataOutRdy   = 1'($urandom);
      O_DataOutRdy   = 1'($urandom);
      @(negedge clk);
      chk("reset_outs", 128'({W_DataOut, I_DataOut, O_DataOut, W_DataOutValid, I_DataOutValid,
                              O_DataOutValid, WL_DataInRdy, A_DataInRdy, P_DataInRdy, busy, done}),
          128'(0));
    end
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_num_blocks = '0;
    WL_DataInValid = 1'b0; A_DataInValid = 1'b0; P_DataInValid = 1'b0;
    W_DataOutRdy = 1'b1; I_DataOutRdy = 1'b1; O_DataOutRdy = 1'b1;
    aclr_n = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal: 2 blocks, weights 5/10/15/20, activations 1..8, seeds 10 and 0.
    wts   = '{32'h40a00000, 32'h41200000, 32'h41700000, 32'h41a00000};
    acts  = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000};
    seeds = '{32'h41200000, 32'h00000000};
    doneCount = 0;
    expectBeats(8);
    startRun(16'd2);
    chk("busy_after_start", 128'(busy), 128'(1));
    loadW();
    cfg_start = 1'b1; cfg_num_blocks = 16'd5;   // must be ignored outside IDLE
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int k = 0; k < 8; k++) pushA(acts[k], (k % 4 == 0), seeds[k / 4], 0);
    waitIdle(wlSeen);
    chk("nom_queue_empty", 128'(expQ.size()), 128'(0));
    chk("nom_done_count", 128'(doneCount), 128'(1));
    chk("nom_done_timing", 128'(doneCyc), 128'(lastFireCyc + 1));

    // Backpressure: O_DataOutRdy alone low for 3 cycles mid-block.
    wts   = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
    acts  = '{32'h11110001, 32'h11110002, 32'h11110003, 32'h11110004,
              32'h11110005, 32'h11110006, 32'h11110007, 32'h11110008};
    seeds = '{32'h40400000, 32'hc0000000};
    doneCount = 0;
    expectBeats(8);
    startRun(16'd2);
    loadW();
    base = fireCount;
    fork
      begin
        for (int k = 0; k < 8; k++) pushA(acts[k], (k % 4 == 0), seeds[k / 4], 0);
      end
      begin
        waitFires(base + 2);
        @(posedge clk); #1;
        O_DataOutRdy = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold", 128'({W_DataOutValid, A_DataInRdy, W_DataOut, I_DataOut, O_DataOut}),
              128'({1'b1, 1'b0, expQ[0]}));
        end
        @(posedge clk); #1;
        O_DataOutRdy = 1'b1;
      end
    join
    waitIdle(wlSeen);
    chk("bp_queue_empty", 128'(expQ.size()), 128'(0));
    chk("bp_done_count", 128'(doneCount), 128'(1));

    // Seed starvation on tap 0, plus WL offered outside LOAD.
    wts   = '{32'h40a00000, 32'h41200000, 32'h41700000, 32'h41a00000};
    acts  = '{32'h22220001, 32'h22220002, 32'h22220003, 32'h22220004,
              32'h0, 32'h0, 32'h0, 32'h0};
    seeds = '{32'h41a00000, 32'h0};
    expectBeats(4);
    startRun(16'd1);
    loadW();
    WL_DataIn = 32'hdeadbeef;
    WL_DataInValid = 1'b1;
    @(negedge clk);
    chk("wl_outside_load", 128'(WL_DataInRdy), 128'(0));
    @(posedge clk); #1;
    pushA(acts[0], 1'b1, seeds[0], 3);
    @(negedge clk);
    chk("starve_emit", 128'(W_DataOutValid), 128'(1));
    @(posedge clk); #1;
    WL_DataInValid = 1'b0;
    for (int k = 1; k < 4; k++) pushA(acts[k], 1'b0, 32'h0, 0);
    waitIdle(wlSeen);
    chk("starve_queue_empty", 128'(expQ.size()), 128'(0));

    // Zero blocks: no weight port, done two cycles after start.
    doneCount = 0;
    WL_DataInValid = 1'b1;
    startRun(16'd0);
    waitIdle(wlSeen);
    WL_DataInValid = 1'b0;
    chk("zero_wl_rdy", 128'(wlSeen), 128'(0));
    chk("zero_done_count", 128'(doneCount), 128'(1));
    chk("zero_done_timing", 128'(doneCyc), 128'(startCyc + 2));

    // Mid-stream reset after 5 fires with a sixth beat in flight.
    wts   = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
    acts  = '{32'h33330001, 32'h33330002, 32'h33330003, 32'h33330004,
              32'h33330005, 32'h33330006, 32'h0, 32'h0};
    seeds = '{32'h40e00000, 32'h41000000};
    expectBeats(5);
    startRun(16'd2);
    loadW();
    base = fireCount;
    for (int k = 0; k < 5; k++) pushA(acts[k], (k % 4 == 0), seeds[k / 4], 0);
    waitFires(base + 5);
    @(posedge clk); #1;
    W_DataOutRdy = 1'b0; I_DataOutRdy = 1'b0; O_DataOutRdy = 1'b0;
    pushA(acts[5], 1'b0, 32'h0, 0);
    @(negedge clk);
    chk("inflight_valid", 128'(W_DataOutValid), 128'(1));
    #2;
    aclr_n = 1'b0;
    #1;
    chk("midreset_clear", 128'({W_DataOut, I_DataOut, O_DataOut, W_DataOutValid, I_DataOutValid,
                                O_DataOutValid, WL_DataInRdy, A_DataInRdy, P_DataInRdy, busy, done}),
        128'(0));
    @(posedge clk); #1;
    aclr_n = 1'b1;
    W_DataOutRdy = 1'b1; I_DataOutRdy = 1'b1; O_DataOutRdy = 1'b1;
    chk("midreset_queue", 128'(expQ.size()), 128'(0));
    @(negedge clk);
    chk("midreset_idle", 128'({busy, W_DataOutValid}), 128'(0));

    // Fresh run after the abort reloads from the first weight slot.
    wts   = '{32'hc0a00000, 32'hc1200000, 32'hc1700000, 32'hc1a00000};
    acts  = '{32'h44440001, 32'h44440002, 32'h44440003, 32'h44440004,
              32'h0, 32'h0, 32'h0, 32'h0};
    seeds = '{32'h3f000000, 32'h0};
    doneCount = 0;
    expectBeats(4);
    startRun(16'd1);
    loadW();
    for (int k = 0; k < 4; k++) pushA(acts[k], (k == 0), seeds[0], 0);
    waitIdle(wlSeen);
    chk("rerun_queue_empty", 128'(expQ.size()), 128'(0));
    chk("rerun_done_count", 128'(doneCount), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
